// File: rtl/pid_cfg_write_arbiter_pkg.sv
// Shared constants and helpers for the pid_pipeline configuration write arbiter.
// Queue entries are packed {addr, chan, data}, with addr in the most significant bits.
package pid_cfg_write_arbiter_pkg;

  localparam int N_REQ_DEF     = 2;
  localparam int W_WR_ADDR_DEF = 16;
  localparam int W_WR_CHAN_DEF = 16;
  localparam int W_WR_DATA_DEF = 48;
  localparam int DEPTH_DEF     = 4;
  localparam int W_PTR_DEF     = 2;

  // Wrap an index that may exceed the requester count by at most one lap.
  function automatic int rr_wrap(input int idx, input int n);
    int r;
    if (idx >= n) begin
      r = idx - n;
    end else begin
      r = idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_cfg_write_arbiter_fifo.sv
// Synchronous FIFO with an occupancy output. Reset discards all queued entries.
// A push while full and a pop while empty are both ignored.
module pid_cfg_write_arbiter_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4,
  parameter int W_PTR = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [W_PTR:0]   level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [W_PTR-1:0] wptr_q, wptr_d;
  logic [W_PTR-1:0] rptr_q, rptr_d;
  logic [W_PTR:0]   level_q, level_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (level_q == (W_PTR+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rptr_q];
  assign level_o   = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + W_PTR'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + W_PTR'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + (W_PTR+1)'(1);
      2'b01:   level_d = level_q - (W_PTR+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pid_cfg_write_arbiter.sv
// Round-robin arbiter sharing the pid_pipeline configuration write bus among N_REQ requesters.
// Accepted writes are queued and issued in acceptance order, at most one per cycle, unless hold_in is set.
module pid_cfg_write_arbiter
  import pid_cfg_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int W_WR_ADDR = W_WR_ADDR_DEF,
  parameter int W_WR_CHAN = W_WR_CHAN_DEF,
  parameter int W_WR_DATA = W_WR_DATA_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int W_PTR     = W_PTR_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W_WR_ADDR-1:0] req_addr,
  input  logic [N_REQ*W_WR_CHAN-1:0] req_chan,
  input  logic [N_REQ*W_WR_DATA-1:0] req_data,
  input  logic                       hold_in,
  output logic                       wr_en,
  output logic [W_WR_ADDR-1:0]       wr_addr,
  output logic [W_WR_CHAN-1:0]       wr_chan,
  output logic [W_WR_DATA-1:0]       wr_data,
  output logic [W_PTR:0]             fifo_level,
  output logic                       busy
);

  localparam int W_ENTRY = W_WR_ADDR + W_WR_CHAN + W_WR_DATA;
  localparam int W_RR    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [W_RR-1:0]      rr_q, rr_d;
  logic [W_RR-1:0]      gidx_s;
  logic [N_REQ-1:0]     grant_s;
  logic                 found_s;
  logic                 fifo_full_s, fifo_empty_s, pop_s;
  logic [W_ENTRY-1:0]   push_entry_s, head_s;
  logic [W_PTR:0]       level_s;
  logic                 wr_en_q, wr_en_d;
  logic [W_WR_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [W_WR_CHAN-1:0] wr_chan_q, wr_chan_d;
  logic [W_WR_DATA-1:0] wr_data_q, wr_data_d;

  // First valid requester at or after the pointer wins; a full queue grants nobody, even if popping.
  always_comb begin
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    rr_d    = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && !fifo_full_s && req_valid[rr_wrap(int'(rr_q) + k, N_REQ)]) begin
        found_s = 1'b1;
        gidx_s  = W_RR'(rr_wrap(int'(rr_q) + k, N_REQ));
        grant_s[rr_wrap(int'(rr_q) + k, N_REQ)] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      rr_d = W_RR'(rr_wrap(int'(gidx_s) + 1, N_REQ));
    end else begin
      rr_d = rr_q;
    end
  end

  assign req_ready    = grant_s;
  assign push_entry_s = {req_addr[int'(gidx_s)*W_WR_ADDR +: W_WR_ADDR],
                         req_chan[int'(gidx_s)*W_WR_CHAN +: W_WR_CHAN],
                         req_data[int'(gidx_s)*W_WR_DATA +: W_WR_DATA]};
  assign pop_s        = !fifo_empty_s && !hold_in;

  pid_cfg_write_arbiter_fifo #(
    .WIDTH (W_ENTRY),
    .DEPTH (DEPTH),
    .W_PTR (W_PTR)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .push_i  (found_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_s)
  );

  // The bus fields keep the last issued write while the strobe is idle.
  always_comb begin
    wr_en_d   = pop_s;
    wr_addr_d = wr_addr_q;
    wr_chan_d = wr_chan_q;
    wr_data_d = wr_data_q;
    if (pop_s) begin
      {wr_addr_d, wr_chan_d, wr_data_d} = head_s;
    end else begin
      wr_addr_d = wr_addr_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_chan_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_chan_q <= wr_chan_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_chan    = wr_chan_q;
  assign wr_data    = wr_data_q;
  assign fifo_level = level_s;
  assign busy       = (level_s != '0) || wr_en_q;

endmodule

// File: tb/tb_pid_cfg_write_arbiter.sv
// Directed self-checking bench for pid_cfg_write_arbiter (N_REQ=2, DEPTH=4).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pid_cfg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_chan;
  logic [95:0] req_data;
  logic        hold;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_chan;
  logic [47:0] wr_data;
  logic [2:0]  fifo_level;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int          lv3   [8] = '{4, 3, 3, 3, 2, 1, 0, 0};
  logic [15:0] addr2 [6] = '{16'h0A00, 16'h0B00, 16'h0A01, 16'h0B01, 16'h0A02, 16'h0B02};
  int          lv5   [8] = '{2, 2, 2, 2, 2, 1, 0, 0};
  logic [15:0] seq5  [6] = '{16'h0F00, 16'h0F01, 16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03};
  int          lv6   [9] = '{4, 3, 3, 2, 2, 1, 1, 0, 0};

  pid_cfg_write_arbiter dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_chan   (req_chan),
    .req_data   (req_data),
    .hold_in    (hold),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_chan    (wr_chan),
    .wr_data    (wr_data),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data carries a fixed tag above the address so data-field routing is also exercised.
  task automatic set_req(input int i, input logic v, input logic [15:0] a);
    req_valid[i]          = v;
    req_addr[i*16 +: 16]  = a;
    req_chan[i*16 +: 16]  = 16'(i + 1);
    req_data[i*48 +: 48]  = {32'hDA7A_0000, a};
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 2'b00;
    req_addr  = '0;
    req_chan  = '0;
    req_data  = '0;
    tick(); tick();
    mid();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    tick(); rst = 1'b0;
    tick(); tick();

    // Single write from requester 0: accepted at once, on the bus two cycles later.
    tick();
    req_valid[0] = 1'b1; req_addr[15:0] = 16'h0010; req_chan[15:0] = 16'd3; req_data[47:0] = 48'h123456789ABC;
    mid();
    chk("t1_ready", 64'(req_ready), 64'b01);
    chk("t1_wr_en_c0", 64'(wr_en), 64'd0);
    tick(); req_valid[0] = 1'b0;
    mid();
    chk("t1_level_c1", 64'(fifo_level), 64'd1);
    chk("t1_wr_en_c1", 64'(wr_en), 64'd0);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    tick(); mid();
    chk("t1_wr_en_c2", 64'(wr_en), 64'd1);
    chk("t1_addr", 64'(wr_addr), 64'h0010);
    chk("t1_chan", 64'(wr_chan), 64'd3);
    chk("t1_data", 64'(wr_data), 64'h123456789ABC);
    chk("t1_level_c2", 64'(fifo_level), 64'd0);
    tick(); mid();
    chk("t1_wr_en_c3", 64'(wr_en), 64'd0);
    chk("t1_addr_hold", 64'(wr_addr), 64'h0010);
    chk("t1_data_hold", 64'(wr_data), 64'h123456789ABC);
    chk("t1_busy_c3", 64'(busy), 64'd0);

    // Hold with six offered writes: four fill the queue, the rest wait until release.
    tick(); hold = 1'b1; set_req(0, 1'b1, 16'h0C00);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t3_fill_ready", 64'(req_ready), 64'b01);
      chk("t3_fill_level", 64'(fifo_level), 64'(k));
      chk("t3_fill_wr_en", 64'(wr_en), 64'd0);
      tick(); set_req(0, 1'b1, 16'h0C01 + 16'(k));
    end
    for (int k = 0; k < 2; k++) begin
      mid();
      chk("t3_full_ready", 64'(req_ready), 64'b00);
      chk("t3_full_level", 64'(fifo_level), 64'd4);
      chk("t3_full_wr_en", 64'(wr_en), 64'd0);
      tick();
    end
    hold = 1'b0;
    for (int j = 0; j < 8; j++) begin
      mid();
      chk("t3_drain_ready", 64'(req_ready), (j == 1 || j == 2) ? 64'b01 : 64'b00);
      chk("t3_drain_wr_en", 64'(wr_en), (j >= 1 && j <= 6) ? 64'd1 : 64'd0);
      if (j >= 1 && j <= 6) chk("t3_drain_addr", 64'(wr_addr), 64'(16'h0C00 + 16'(j - 1)));
      chk("t3_drain_level", 64'(fifo_level), 64'(lv3[j]));
      tick();
      if (j == 1) set_req(0, 1'b1, 16'h0C05);
      if (j == 2) set_req(0, 1'b0, 16'h0000);
    end

    // Three entries queued, then a one-cycle reset with hold released: nothing may issue.
    hold = 1'b1; set_req(0, 1'b1, 16'h0E00);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t4_fill_ready", 64'(req_ready), 64'b01);
      tick();
      if (k < 2) set_req(0, 1'b1, 16'h0E01 + 16'(k));
      else       set_req(0, 1'b0, 16'h0000);
    end
    rst = 1'b1; hold = 1'b0;
    mid();
    chk("t4_level_pre", 64'(fifo_level), 64'd3);
    tick(); rst = 1'b0;
    mid();
    chk("t4_wr_en", 64'(wr_en), 64'd0);
    chk("t4_level", 64'(fifo_level), 64'd0);
    chk("t4_addr", 64'(wr_addr), 64'd0);
    chk("t4_chan", 64'(wr_chan), 64'd0);
    chk("t4_data", 64'(wr_data), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    tick(); mid();
    chk("t4_wr_en_post", 64'(wr_en), 64'd0);
    chk("t4_level_post", 64'(fifo_level), 64'd0);

    // Both requesters valid: strict alternation starting at requester 0 after reset.
    tick(); set_req(0, 1'b1, 16'h0A00); set_req(1, 1'b1, 16'h0B00);
    for (int k = 0; k < 9; k++) begin
      mid();
      chk("t2_ready", 64'(req_ready), (k < 6) ? ((k % 2 == 0) ? 64'b01 : 64'b10) : 64'b00);
      chk("t2_wr_en", 64'(wr_en), (k >= 2 && k < 8) ? 64'd1 : 64'd0);
      if (k >= 2 && k < 8) chk("t2_addr", 64'(wr_addr), 64'(addr2[k - 2]));
      if (k >= 2 && k < 8) chk("t2_data", 64'(wr_data), {16'h0, 32'hDA7A_0000, addr2[k - 2]});
      if (k == 8) chk("t2_addr_hold", 64'(wr_addr), 64'h0B02);
      chk("t2_level", 64'(fifo_level), (k == 0) ? 64'd0 : ((k <= 6) ? 64'd1 : 64'd0));
      tick();
      if (k < 6) begin
        if (k / 2 + 1 < 3) set_req(k % 2, 1'b1, ((k % 2 == 0) ? 16'h0A00 : 16'h0B00) + 16'(k / 2 + 1));
        else               set_req(k % 2, 1'b0, 16'h0000);
      end
    end

    // Level held at 2 while requester 1 pushes every cycle and the queue drains.
    hold = 1'b1; set_req(0, 1'b1, 16'h0F00);
    mid(); chk("t5_pre_ready0", 64'(req_ready), 64'b01);
    tick(); set_req(0, 1'b1, 16'h0F01);
    mid(); chk("t5_pre_ready1", 64'(req_ready), 64'b01);
    chk("t5_pre_level", 64'(fifo_level), 64'd1);
    tick(); set_req(0, 1'b0, 16'h0000); hold = 1'b0; set_req(1, 1'b1, 16'h0D00);
    for (int p = 0; p < 8; p++) begin
      mid();
      chk("t5_level", 64'(fifo_level), 64'(lv5[p]));
      chk("t5_ready", 64'(req_ready), (p <= 3) ? 64'b10 : 64'b00);
      chk("t5_wr_en", 64'(wr_en), (p >= 1 && p <= 6) ? 64'd1 : 64'd0);
      if (p >= 1 && p <= 6) chk("t5_addr", 64'(wr_addr), 64'(seq5[p - 1]));
      tick();
      if (p < 3)       set_req(1, 1'b1, 16'h0D01 + 16'(p));
      else if (p == 3) set_req(1, 1'b0, 16'h0000);
    end

    // Four queued, hold toggling: a write follows only each cycle that sampled hold low.
    hold = 1'b1; set_req(0, 1'b1, 16'h0900);
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t6_fill_ready", 64'(req_ready), 64'b01);
      tick();
      if (k < 3) set_req(0, 1'b1, 16'h0901 + 16'(k));
      else       set_req(0, 1'b0, 16'h0000);
    end
    hold = 1'b0;
    for (int q = 0; q < 9; q++) begin
      mid();
      chk("t6_wr_en", 64'(wr_en), (q % 2 == 1) ? 64'd1 : 64'd0);
      if (q % 2 == 1) chk("t6_addr", 64'(wr_addr), 64'(16'h0900 + 16'((q - 1) / 2)));
      chk("t6_level", 64'(fifo_level), 64'(lv6[q]));
      tick();
      hold = (q % 2 == 0) ? 1'b1 : 1'b0;
    end
    mid();
    chk("t6_busy_end", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
